io_device_responder: RTL and testbench
======================================

Name: io_device_responder

Overview:
- Device-side end of the processor's 4-channel I/O handshake.
- Sinks processor output requests on enter_out/dev_out and acknowledges each with done_out.
- Sources input words to the processor on dev_in/enter_in from per-channel FIFOs filled by external producers (switches, keypad, disk stub).
- Sits beside the processor at the machine level; its ports face the processor's dev_*/enter_*/done_out/in_ready ports.

Parameters:
- NCH, 4, number of channels; channel i uses bits [32i+31:32i] of every 128-bit bus.
- OUT_LATENCY, 2, cycles between capture of an output word and done_out rising, minus one; range 0..15.
- IN_DEPTH, 4, entries per channel input FIFO; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enter_out  in  4  processor output request per channel; level, held until done_out seen.
- dev_out  in  128  processor output data, 32 bits per channel; valid while enter_out[i]=1.
- done_out  out  4  output acknowledge per channel; level.
- in_ready  in  1  processor able to accept input words this cycle.
- dev_in  out  128  input word per channel; registered, holds last delivered value.
- enter_in  out  4  one-cycle pulse: new word on the dev_in slice.
- ext_in_data  in  128  external producer data, 32 bits per channel.
- ext_in_valid  in  4  external push request per channel.
- ext_in_full  out  4  channel FIFO full; a push is ignored while this is 1.
- ext_out_data  out  128  last captured output word per channel.
- ext_out_strobe  out  4  one-cycle pulse in the cycle after capture.

Behaviour:
- Reset: every output is 0, every FIFO is empty, and every output FSM is in IDLE. Reset applies immediately and asynchronously, including mid-handshake; an in-progress done_out drops at once.
- Channels are fully independent; simultaneous activity on all 4 channels is legal.

Output FSM (per channel): states IDLE, WAIT, ACK.
- IDLE: at an edge with enter_out[i]=1, capture the dev_out slice into ext_out_data[i], pulse ext_out_strobe[i] next cycle, load counter=OUT_LATENCY, go to WAIT.
- WAIT: if enter_out[i]=0, abort to IDLE; no done_out, ext_out_data is kept. Otherwise, if counter=0 go to ACK, else decrement.
- ACK: done_out[i]=1. Remain until enter_out[i]=0, then go to IDLE (done_out falls the same edge).
- Timing: done_out rises exactly OUT_LATENCY+1 clocks after the capture edge.
- A request held high after ACK→IDLE is not re-captured until enter_out has been seen low; this is a four-phase protocol.

Input path (per channel):
- FIFO with IN_DEPTH entries; head/tail pointers are log2(IN_DEPTH)+1 bits wide, and wrap-around uses the MSB to tell full from empty.
- Push when ext_in_valid[i]=1 and not full. A push against full is dropped with no error flag; ext_in_full is combinational from the pointers.
- Pop when in_ready=1 and the FIFO is non-empty. At that edge the head word is registered into the dev_in slice and enter_in[i] is 1 for the following cycle only.
- Push and pop in the same cycle on a non-empty, non-full FIFO both occur, and the count is unchanged.
- Push to an empty FIFO is not visible to pop until the next cycle, so the minimum latency from ext_in_valid to enter_in is 2 clocks.
- When full, a same-cycle push is still dropped even if a pop also occurs.
- With in_ready held high and the FIFO non-empty, one word is delivered per clock, back-to-back.

Decomposition:
- Shared package io_pkg: output FSM state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2), the constant CH_W=32, and a slice-index helper function.
- One natural sub-module: io_channel. It holds one output FSM and one input FIFO and is instantiated NCH times by a generate loop in io_device_responder.

Test Plan:
- Reset mid-ACK: drive enter_out[0]=1 until done_out[0]=1, then pull rst_n low asynchronously → done_out, enter_in and ext_out_data are 0 immediately; FSM is in IDLE after release.
- Output latency: OUT_LATENCY=2, dev_out[31:0]=32'hDEADBEEF, enter_out[0] high at edge t → ext_out_strobe[0] pulses at t+1, ext_out_data[31:0]=DEADBEEF, done_out[0] rises at t+3; dropping enter_out at t+5 → done_out low at t+6.
- Abort: drop enter_out[2] during WAIT → done_out[2] never rises; a new request 32'h0000_0055 is captured normally afterwards.
- FIFO fill and overflow: in_ready=0, push 5 words 1..5 on channel 1 → ext_in_full[1]=1 after the 4th push; word 5 is dropped. Raising in_ready → enter_in[1] pulses 4 consecutive cycles with dev_in[63:32]=1,2,3,4.
- Simultaneous push/pop: FIFO holds 2 words and in_ready=1 with a push of 32'hA5 → count stays 2 and order is preserved.
- Concurrency: requests on all 4 channels in the same cycle plus pushes on all 4 → every done_out rises at the same cycle and every channel delivers its own data.

Source files
------------

// File: rtl/io_pkg.sv
// ============================================================================
// Module  : io_pkg
// Purpose : Shared types, widths and slice helper for the device responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

    localparam int CH_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } out_state_t;

    // Low bit index of channel ch within a packed multi-channel bus.
    function automatic int ch_lo(input int ch);
        return ch * CH_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_channel.sv
// ============================================================================
// Module  : io_channel
// Purpose : One channel: four-phase output acknowledge FSM plus input FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module io_channel
    import io_pkg::*;
#(
    parameter int OUT_LATENCY = 2,
    parameter int IN_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_enter_out,
    input  logic [CH_W-1:0] i_dev_out,
    output logic            o_done_out,
    input  logic            i_in_ready,
    output logic [CH_W-1:0] o_dev_in,
    output logic            o_enter_in,
    input  logic [CH_W-1:0] i_ext_in_data,
    input  logic            i_ext_in_valid,
    output logic            o_ext_in_full,
    output logic [CH_W-1:0] o_ext_out_data,
    output logic            o_ext_out_strobe
);

    localparam int c_addr_w = $clog2(IN_DEPTH);

    // ---------------------------------------------------------------- output
    out_state_t      r_state;
    out_state_t      w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic            w_capture;
    logic [CH_W-1:0] r_out_data;
    logic            r_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_out_data <= '0;
            r_strobe   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_strobe <= w_capture;
            if (w_capture) begin
                r_out_data <= i_dev_out;
            end
        end
    end

    // ACK only exits on a low request, so IDLE never sees a stale held request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enter_out) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 4'(OUT_LATENCY);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!i_enter_out) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ACK: begin
                if (!i_enter_out) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_done_out       = (r_state == ACK);
    assign o_ext_out_data   = r_out_data;
    assign o_ext_out_strobe = r_strobe;

    // ----------------------------------------------------------------- input
    logic [CH_W-1:0]   r_mem [IN_DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [CH_W-1:0]   r_dev_in;
    logic              r_enter_in;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_push  = i_ext_in_valid && !w_full;
    assign w_pop   = i_in_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_ext_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_dev_in   <= '0;
            r_enter_in <= 1'b0;
        end else begin
            r_enter_in <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{c_addr_w{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{c_addr_w{1'b0}}, 1'b1};
                r_dev_in <= r_mem[r_rd_ptr[c_addr_w-1:0]];
            end
        end
    end

    assign o_ext_in_full = w_full;
    assign o_dev_in      = r_dev_in;
    assign o_enter_in    = r_enter_in;

endmodule

`default_nettype wire

// File: rtl/io_device_responder.sv
// ============================================================================
// Module  : io_device_responder
// Purpose : Device side of the processor's multi-channel I/O handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module io_device_responder
    import io_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int OUT_LATENCY = 2,
    parameter int IN_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      enter_out,
    input  logic [NCH*CH_W-1:0] dev_out,
    output logic [NCH-1:0]      done_out,
    input  logic                in_ready,
    output logic [NCH*CH_W-1:0] dev_in,
    output logic [NCH-1:0]      enter_in,
    input  logic [NCH*CH_W-1:0] ext_in_data,
    input  logic [NCH-1:0]      ext_in_valid,
    output logic [NCH-1:0]      ext_in_full,
    output logic [NCH*CH_W-1:0] ext_out_data,
    output logic [NCH-1:0]      ext_out_strobe
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        io_channel #(
            .OUT_LATENCY (OUT_LATENCY),
            .IN_DEPTH    (IN_DEPTH)
        ) u_channel (
            .clk              (clk),
            .rst_n            (rst_n),
            .i_enter_out      (enter_out[g]),
            .i_dev_out        (dev_out[ch_lo(g) +: CH_W]),
            .o_done_out       (done_out[g]),
            .i_in_ready       (in_ready),
            .o_dev_in         (dev_in[ch_lo(g) +: CH_W]),
            .o_enter_in       (enter_in[g]),
            .i_ext_in_data    (ext_in_data[ch_lo(g) +: CH_W]),
            .i_ext_in_valid   (ext_in_valid[g]),
            .o_ext_in_full    (ext_in_full[g]),
            .o_ext_out_data   (ext_out_data[ch_lo(g) +: CH_W]),
            .o_ext_out_strobe (ext_out_strobe[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_io_device_responder.sv
// ============================================================================
// Module  : tb_io_device_responder
// Purpose : Randomised scoreboard bench for io_device_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_device_responder;

    localparam int NCH   = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     enter_out    = '0;
    logic [NCH*W-1:0]   dev_out      = '0;
    logic [NCH-1:0]     done_out;
    logic               in_ready     = 1'b0;
    logic [NCH*W-1:0]   dev_in;
    logic [NCH-1:0]     enter_in;
    logic [NCH*W-1:0]   ext_in_data  = '0;
    logic [NCH-1:0]     ext_in_valid = '0;
    logic [NCH-1:0]     ext_in_full;
    logic [NCH*W-1:0]   ext_out_data;
    logic [NCH-1:0]     ext_out_strobe;

    io_device_responder #(
        .NCH         (NCH),
        .OUT_LATENCY (LAT),
        .IN_DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enter_out      (enter_out),
        .dev_out        (dev_out),
        .done_out       (done_out),
        .in_ready       (in_ready),
        .dev_in         (dev_in),
        .enter_in       (enter_in),
        .ext_in_data    (ext_in_data),
        .ext_in_valid   (ext_in_valid),
        .ext_in_full    (ext_in_full),
        .ext_out_data   (ext_out_data),
        .ext_out_strobe (ext_out_strobe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model: a request is acknowledged once it has been seen high
    // for LAT+2 consecutive edges; the input side is a bounded word queue.
    int          run        [NCH];
    logic [31:0] model_q    [NCH][$];
    logic [31:0] exp_del    [NCH][$];
    logic [31:0] exp_cap    [NCH][$];
    logic        exp_done   [NCH];
    logic        exp_pulse  [NCH];
    logic        exp_strobe [NCH];
    logic        exp_full   [NCH];
    logic [31:0] exp_dev_in [NCH];
    logic [31:0] exp_out    [NCH];

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s ch%0d at %0t: got %h, expected %h", name, c, $time, act, want);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            run[c] = 0;
            model_q[c].delete();
            exp_del[c].delete();
            exp_cap[c].delete();
            exp_done[c] = 1'b0;
            exp_pulse[c] = 1'b0;
            exp_strobe[c] = 1'b0;
            exp_full[c] = 1'b0;
            exp_dev_in[c] = '0;
            exp_out[c] = '0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] dv;
            logic [31:0] di;
            bit          do_pop;
            bit          do_push;
            dv = dev_out[c*W +: W];
            di = ext_in_data[c*W +: W];
            exp_strobe[c] = 1'b0;
            if (enter_out[c]) begin
                run[c]++;
                if (run[c] == 1) begin
                    exp_strobe[c] = 1'b1;
                    exp_out[c] = dv;
                    exp_cap[c].push_back(dv);
                end
            end else begin
                run[c] = 0;
            end
            exp_done[c] = (run[c] >= LAT + 2);
            do_pop  = in_ready && (model_q[c].size() > 0);
            do_push = ext_in_valid[c] && (model_q[c].size() < DEPTH);
            exp_pulse[c] = do_pop;
            if (do_pop) begin
                exp_dev_in[c] = model_q[c].pop_front();
                exp_del[c].push_back(exp_dev_in[c]);
            end
            if (do_push) model_q[c].push_back(di);
            exp_full[c] = (model_q[c].size() == DEPTH);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: level checks every cycle, scoreboard pops on each DUT pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NCH; c++) begin
                chk("done_out", c, 32'(done_out[c]), 32'(exp_done[c]));
                chk("ext_in_full", c, 32'(ext_in_full[c]), 32'(exp_full[c]));
                chk("enter_in", c, 32'(enter_in[c]), 32'(exp_pulse[c]));
                chk("ext_out_strobe", c, 32'(ext_out_strobe[c]), 32'(exp_strobe[c]));
                chk("dev_in_hold", c, dev_in[c*W +: W], exp_dev_in[c]);
                chk("ext_out_data_hold", c, ext_out_data[c*W +: W], exp_out[c]);
                if (enter_in[c]) begin
                    if (exp_del[c].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL deliver ch%0d at %0t: got %h, expected no delivery",
                                 c, $time, dev_in[c*W +: W]);
                    end else begin
                        chk("deliver", c, dev_in[c*W +: W], exp_del[c].pop_front());
                    end
                end
                if (ext_out_strobe[c]) begin
                    if (exp_cap[c].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL capture ch%0d at %0t: got %h, expected no capture",
                                 c, $time, ext_out_data[c*W +: W]);
                    end else begin
                        chk("capture", c, ext_out_data[c*W +: W], exp_cap[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_done_out", 0, 32'(done_out), 32'd0);
        chk("rst_enter_in", 0, 32'(enter_in), 32'd0);
        chk("rst_strobe", 0, 32'(ext_out_strobe), 32'd0);
        chk("rst_full", 0, 32'(ext_in_full), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Output latency on channel 0.
        dev_out[31:0] = 32'hDEADBEEF;
        enter_out[0]  = 1'b1;
        repeat (6) step();
        enter_out[0] = 1'b0;
        repeat (2) step();

        // Abort during WAIT on channel 2, then a normal request.
        dev_out[2*W +: W] = 32'h0000_0077;
        enter_out[2] = 1'b1;
        repeat (2) step();
        enter_out[2] = 1'b0;
        repeat (2) step();
        dev_out[2*W +: W] = 32'h0000_0055;
        enter_out[2] = 1'b1;
        repeat (6) step();
        enter_out[2] = 1'b0;
        repeat (2) step();

        // Fill channel 1 past capacity, then drain back-to-back.
        in_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            ext_in_valid[1] = 1'b1;
            ext_in_data[W +: W] = 32'(v);
            step();
        end
        ext_in_valid[1] = 1'b0;
        step();
        in_ready = 1'b1;
        repeat (6) step();

        // Simultaneous push and pop on channel 3.
        in_ready = 1'b0;
        ext_in_valid[3] = 1'b1;
        ext_in_data[3*W +: W] = 32'h11;
        step();
        ext_in_data[3*W +: W] = 32'h22;
        step();
        in_ready = 1'b1;
        ext_in_data[3*W +: W] = 32'hA5;
        step();
        ext_in_valid[3] = 1'b0;
        in_ready = 1'b0;
        step();
        in_ready = 1'b1;
        repeat (4) step();

        // All channels at once.
        for (int c = 0; c < NCH; c++) begin
            enter_out[c] = 1'b1;
            dev_out[c*W +: W] = 32'h1000_0000 + 32'(c);
            ext_in_valid[c] = 1'b1;
            ext_in_data[c*W +: W] = 32'h2000_0000 + 32'(c);
        end
        step();
        ext_in_valid = '0;
        repeat (5) step();
        enter_out = '0;
        repeat (2) step();

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (enter_out[c]) begin
                    if ($urandom_range(5) == 0) enter_out[c] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    enter_out[c] = 1'b1;
                end
                dev_out[c*W +: W]     = $urandom;
                ext_in_valid[c]       = 1'($urandom_range(1));
                ext_in_data[c*W +: W] = $urandom;
            end
            if ((n % 200) < 100) in_ready = ($urandom_range(3) == 0);
            else                 in_ready = ($urandom_range(3) != 0);
            step();
        end
        enter_out = '0;
        ext_in_valid = '0;
        in_ready = 1'b1;
        repeat (8) step();

        // Asynchronous reset while channel 0 is acknowledging.
        dev_out[31:0] = 32'h0000_1234;
        enter_out[0] = 1'b1;
        k = 0;
        while (!done_out[0] && k < 20) begin
            step();
            k++;
        end
        chk("reach_ack", 0, 32'(done_out[0]), 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_done_out", 0, 32'(done_out), 32'd0);
        chk("async_enter_in", 0, 32'(enter_in), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            chk("async_ext_out_data", c, ext_out_data[c*W +: W], 32'd0);
            chk("async_dev_in", c, dev_in[c*W +: W], 32'd0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (6) step();
        enter_out = '0;
        repeat (3) step();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
